// File: rtl/unlock_pkg.sv
// Shared definitions for the unlocking-path serial blocks: default widths,
// the bit-counter width helper and the word-counter type.
package unlock_pkg;

    localparam int N_DEFAULT     = 4;
    localparam int CNT_W_DEFAULT = 8;

    // The bit counter must represent 0..N inclusive, because N marks a
    // complete word parked in the shift register.
    function automatic int BITCNT_W(input int n);
        return $clog2(n + 1);
    endfunction

    typedef logic [CNT_W_DEFAULT-1:0] word_cnt_t;

endpackage

// File: rtl/s2p_converter_if.sv
// Serial-in and parallel-out handshake bundle for the s2p_converter.
// Handshake: a beat transfers on a rising clk edge where valid && ready;
// valid must not depend on ready, and data is held while valid && !ready.
interface s2p_converter_if
    import unlock_pkg::*;
#(
    parameter int N = N_DEFAULT
);

    logic         s_data;
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] p_data;
    logic         p_valid;
    logic         p_ready;

    modport slave (
        input  s_data,
        input  s_valid,
        input  p_ready,
        output s_ready,
        output p_data,
        output p_valid
    );

    modport master (
        output s_data,
        output s_valid,
        output p_ready,
        input  s_ready,
        input  p_data,
        input  p_valid
    );

endinterface

// File: rtl/s2p_converter.sv
// Serial-to-parallel deserializer: shift register feeding an output register,
// so a new word can assemble while the previous one waits to be accepted.
module s2p_converter
    import unlock_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    s2p_converter_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int             BCW  = BITCNT_W(N);
    localparam logic [BCW-1:0] LAST = BCW'(N - 1);
    localparam logic [BCW-1:0] FULL = BCW'(N);

    logic [BCW-1:0]   r_bit_cnt;
    logic [N-1:0]     r_shift;
    logic [N-1:0]     r_out;
    logic             r_out_full;
    logic [CNT_W-1:0] r_word_cnt;

    logic             w_s_ready;
    logic             w_busy;
    logic             w_s_xfer;
    logic             w_p_xfer;
    logic             w_complete;
    logic             w_pending;
    logic             w_load;
    logic [N-1:0]     w_shift_next;

    // Ready and busy decode registered state only; nothing from p_ready or
    // s_valid reaches s_ready combinationally.
    always_comb begin
        w_s_ready    = (r_bit_cnt < FULL);
        w_busy       = (r_bit_cnt != '0);
        w_s_xfer     = bus.s_valid && w_s_ready;
        w_p_xfer     = r_out_full && bus.p_ready;
        w_complete   = w_s_xfer && (r_bit_cnt == LAST);
        w_pending    = (r_bit_cnt == FULL);
        w_load       = (w_complete || w_pending) && (!r_out_full || w_p_xfer);
        w_shift_next = MSB_FIRST ? {r_shift[N-2:0], bus.s_data}
                                 : {bus.s_data, r_shift[N-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_load) begin
            r_bit_cnt <= '0;
            if (w_s_xfer) begin
                r_shift <= w_shift_next;
            end
        end else if (w_s_xfer) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + BCW'(1);
        end
    end

    // A parked word comes from r_shift; a word finishing this cycle comes
    // straight from the shifter so it is visible one cycle after its last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out      <= '0;
            r_out_full <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            if (w_load) begin
                r_out      <= w_pending ? r_shift : w_shift_next;
                r_out_full <= 1'b1;
            end else if (w_p_xfer) begin
                r_out_full <= 1'b0;
            end
            if (w_p_xfer) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.p_data  = r_out;
    assign bus.p_valid = r_out_full;
    assign busy        = w_busy;
    assign word_cnt    = r_word_cnt;

endmodule

// File: tb/tb_s2p_converter.sv
// Bench for s2p_converter: three instances (MSB-first, LSB-first, 2-bit word
// counter) share one serial stream and are compared every cycle to a word model.
module tb_s2p_converter;

    localparam int N = 4;

    logic clk;
    logic rst_n;
    logic s_data;
    logic s_valid;
    logic p_ready;

    logic       busy_a, busy_b, busy_c;
    logic [7:0] word_cnt_a, word_cnt_b;
    logic [1:0] word_cnt_c;

    s2p_converter_if #(.N(N)) if_a ();
    s2p_converter_if #(.N(N)) if_b ();
    s2p_converter_if #(.N(N)) if_c ();

    assign if_a.s_data = s_data;  assign if_a.s_valid = s_valid;  assign if_a.p_ready = p_ready;
    assign if_b.s_data = s_data;  assign if_b.s_valid = s_valid;  assign if_b.p_ready = p_ready;
    assign if_c.s_data = s_data;  assign if_c.s_valid = s_valid;  assign if_c.p_ready = p_ready;

    s2p_converter #(.N(N), .MSB_FIRST(1'b1), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave), .busy(busy_a), .word_cnt(word_cnt_a)
    );
    s2p_converter #(.N(N), .MSB_FIRST(1'b0), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave), .busy(busy_b), .word_cnt(word_cnt_b)
    );
    s2p_converter #(.N(N), .MSB_FIRST(1'b1), .CNT_W(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c.slave), .busy(busy_c), .word_cnt(word_cnt_c)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Bits collected so far are kept in arrival order; a word is formed only
    // when N bits are in hand and the output slot is free.
    int          m_cnt;
    logic [31:0] m_bits;
    logic [N-1:0] m_word_msb;
    logic [N-1:0] m_word_lsb;
    logic        m_valid;
    int          m_words;

    task automatic model_reset();
        m_cnt      = 0;
        m_bits     = '0;
        m_word_msb = '0;
        m_word_lsb = '0;
        m_valid    = 1'b0;
        m_words    = 0;
    endtask

    task automatic model_step();
        logic accept_word;
        accept_word = m_valid && p_ready;
        if (s_valid && m_cnt < N) begin
            m_bits[m_cnt] = s_data;
            m_cnt++;
        end
        if (accept_word) begin
            m_valid = 1'b0;
            m_words++;
        end
        if (m_cnt == N && !m_valid) begin
            for (int i = 0; i < N; i++) begin
                m_word_msb[N-1-i] = m_bits[i];
                m_word_lsb[i]     = m_bits[i];
            end
            m_valid = 1'b1;
            m_cnt   = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".p_valid"},  32'(if_a.p_valid), 32'(m_valid));
        check({tag, ".p_data_a"}, 32'(if_a.p_data),  32'(m_word_msb));
        check({tag, ".p_data_b"}, 32'(if_b.p_data),  32'(m_word_lsb));
        check({tag, ".s_ready"},  32'(if_a.s_ready), 32'(m_cnt < N));
        check({tag, ".busy"},     32'(busy_a),       32'(m_cnt != 0));
        check({tag, ".cnt_a"},    32'(word_cnt_a),   32'(m_words % 256));
        check({tag, ".cnt_c"},    32'(word_cnt_c),   32'(m_words % 4));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic sv, input logic sd, input logic pr, input string tag);
        s_valid = sv;
        s_data  = sd;
        p_ready = pr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic pr, input string tag);
        for (int i = 0; i < N; i++) cycle(1'b1, w[N-1-i], pr, tag);
    endtask

    task automatic do_reset(input string tag);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all({tag, ".async"});
        check({tag, ".busy_b"}, 32'(busy_b), 32'(0));
        @(negedge clk);
        compare_all({tag, ".held"});
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        s_data  = 1'b0;
        s_valid = 1'b0;
        p_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        check("reset.busy_c", 32'(busy_c), 32'(0));
        rst_n = 1'b1;

        // Single word, MSB-first and LSB-first lanes.
        send_word(4'b1011, 1'b1, "word1");
        check("word1.msb_const", 32'(if_a.p_data), 32'(4'b1011));
        check("word1.lsb_const", 32'(if_b.p_data), 32'(4'b1101));
        cycle(1'b0, 1'b0, 1'b1, "word1.drain");
        check("word1.cnt_const", 32'(word_cnt_a), 32'(1));

        // Back-to-back words with the sink always ready.
        send_word(4'b1011, 1'b1, "stream");
        send_word(4'b0110, 1'b1, "stream");
        send_word(4'b1111, 1'b1, "stream");
        cycle(1'b0, 1'b0, 1'b1, "stream.drain");

        // Backpressure: second word parks in the shift register.
        send_word(4'b1010, 1'b0, "bp");
        send_word(4'b0101, 1'b0, "bp");
        check("bp.hold_const", 32'(if_a.p_data), 32'(4'b1010));
        check("bp.sready_const", 32'(if_a.s_ready), 32'(0));
        cycle(1'b1, 1'b1, 1'b0, "bp.refused");
        cycle(1'b1, 1'b0, 1'b0, "bp.refused");
        cycle(1'b0, 1'b0, 1'b1, "bp.release");
        check("bp.next_const", 32'(if_a.p_data), 32'(4'b0101));
        check("bp.sready_up", 32'(if_a.s_ready), 32'(1));
        cycle(1'b0, 1'b0, 1'b1, "bp.drain");

        // Reset in the middle of a word discards the partial bits.
        cycle(1'b1, 1'b1, 1'b1, "midrst");
        cycle(1'b1, 1'b1, 1'b1, "midrst");
        do_reset("midrst");
        send_word(4'b0011, 1'b1, "after_rst");
        check("after_rst.const", 32'(if_a.p_data), 32'(4'b0011));
        cycle(1'b0, 1'b0, 1'b1, "after_rst.drain");
        check("after_rst.cnt", 32'(word_cnt_a), 32'(1));

        // Five words so the 2-bit counter wraps through 0.
        for (int w = 0; w < 5; w++) begin
            send_word(4'($urandom_range(0, 15)), 1'b1, "wrap");
        end
        cycle(1'b0, 1'b0, 1'b1, "wrap.drain");
        check("wrap.cnt_c", 32'(word_cnt_c), 32'(2));

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset("rnd_rst");
            end else begin
                cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 9) < 5), "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/s2p_converter.md
Name: s2p_converter

Overview:
Serial-to-parallel deserializer. It is the receiving end of the same 1-bit valid/ready serial stream that the unlocking path's parallel-to-serial converter produces. It collects N serial bits into an N-bit word and presents it on a parallel valid/ready interface. Double-buffered (shift register plus output register), so sustained throughput is one word per N cycles with no bubbles. It sits wherever a serialized password or code must be reassembled, such as loopback checking of the unlocking path or a remote keypad link.

Parameters:
N, 4, parallel word width in bits; legal range 2..32.
MSB_FIRST, 1, 1: first serial bit lands in p_data[N-1]; 0: first serial bit lands in p_data[0].
CNT_W, 8, width of the emitted-word counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
s_data  input  1  serial data bit
s_valid  input  1  serial bit valid
s_ready  output  1  converter can accept a serial bit this cycle
p_data  output  N  assembled parallel word
p_valid  output  1  p_data holds a complete word
p_ready  input  1  downstream accepts p_data this cycle
busy  output  1  partial word in progress (bit_cnt != 0)
word_cnt  output  CNT_W  number of words handed off on the parallel side, wraps modulo 2^CNT_W

Behaviour:
- Transfer rules: a serial transfer occurs when s_valid && s_ready. A parallel transfer occurs when p_valid && p_ready.
- Reset values (async assert, sync release): p_data=0, p_valid=0, word_cnt=0, bit_cnt=0, shift register=0, busy=0, s_ready=1. No transfer is recorded while rst_n is low.
- State: bit_cnt in 0..N; shift_reg N bits; out_reg N bits with out_full flag. p_valid = out_full and p_data = out_reg, both registered.
- s_ready = (bit_cnt < N). It is a registered-state decode only, with no combinational path from p_ready or s_valid.
- Shifting on each serial transfer:
  - MSB_FIRST=1: shift_reg <= {shift_reg[N-2:0], s_data}.
  - MSB_FIRST=0: shift_reg <= {s_data, shift_reg[N-1:1]}.
  - bit_cnt increments.
- Completing bit (serial transfer while bit_cnt==N-1):
  - If !out_full or a parallel transfer happens in the same cycle: the completed word (including the new bit) is written to out_reg, out_full <= 1, and bit_cnt <= 0.
  - Otherwise: bit_cnt <= N, the shift register holds the full word, and s_ready drops.
- Pending word (bit_cnt==N): on a parallel transfer, shift_reg moves to out_reg, out_full stays 1, bit_cnt <= 0, and s_ready rises the next cycle.
- Parallel transfer with no new word ready: out_full <= 0.
- word_cnt increments by 1 on every parallel transfer and wraps from 2^CNT_W-1 to 0.
- Latency: the last serial bit accepted in cycle t gives p_valid=1 with the word in cycle t+1.
- p_data is stable while p_valid && !p_ready; it never changes under an unaccepted valid.
- s_valid low mid-word: bit_cnt holds and the partial word is kept indefinitely, with no timeout.
- Reset mid-word or with an output pending: all state clears and the partial or pending word is discarded.
- Simultaneous completing serial bit and parallel accept: both happen in that cycle, with no lost or duplicated word.

Decomposition:
- Shared package unlock_pkg: localparam default N=4; function clog2-based BITCNT_W(N) (bit_cnt needs $clog2(N+1) bits); typedef for the word-counter type.
- No sub-module. The shift/count datapath and the output register are a single always_ff block each, plus an always_comb for the s_ready/busy decode.

Test Plan:
- N=4, MSB_FIRST=1, p_ready=1, serial bits 1,0,1,1 on consecutive cycles -> p_valid one cycle after the 4th bit, p_data=4'b1011, word_cnt=1.
- MSB_FIRST=0, same bits 1,0,1,1 -> p_data=4'b1101.
- Continuous s_valid=1 with 3 words (1011, 0110, 1111) and p_ready=1 -> p_valid pulses every 4 cycles, words in order, s_ready never drops.
- Backpressure:
  - Stimulus: p_ready=0, send 8 bits (words A=1010, B=0101).
  - Required: p_data=1010 held stable; s_ready=0 after the 8th bit; bits 9+ are not accepted.
  - Then raise p_ready for 1 cycle: p_data=0101 next cycle, s_ready=1.
- Reset: rst_n low after 2 bits of a word, then release and send 0,0,1,1 -> p_data=4'b0011. The stale bits do not appear, word_cnt=1, busy=0 during reset.
- CNT_W=2, send 5 words with p_ready=1 -> word_cnt sequence 1,2,3,0,1.
